// File: rtl/vec_mem_port.sv
// vec_mem_port: memory-stage port for the 8-lane vector pipeline.
//
// A vector store is split into LANES beats of LW bits on a narrow req/ack
// memory bus. A vector load gathers LANES beats into one wide ReadDataM.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   MemWriteM, MemtoRegM  store / load request from the EM register
//   ALUResultM            lane 0 carries the base byte address
//   WriteDataM            store data, lane i at [i*LW +: LW]
//   StallM                holds upstream stages until the transfer retires
//   ReadDataM, RDValidM   gathered load data and its one-cycle valid pulse
//   mem_req/we/addr/wdata beat request towards data memory
//   mem_ack, mem_rdata    beat accept / read data from data memory
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | waiting for a request; store wins over load
// S_WRITE | issuing store beats, one per mem_ack
// S_READ  | issuing load beats, gathering mem_rdata per mem_ack
// S_DONE  | one retire cycle; for a load ReadDataM is fresh here
module vec_mem_port #(
    parameter int LANES = 8,
    parameter int LW    = 32,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWriteM,
    input  logic                MemtoRegM,
    input  logic [LANES*LW-1:0] ALUResultM,
    input  logic [LANES*LW-1:0] WriteDataM,
    output logic                StallM,
    output logic [LANES*LW-1:0] ReadDataM,
    output logic                RDValidM,
    output logic                mem_req,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [LW-1:0]       mem_wdata,
    input  logic                mem_ack,
    input  logic [LW-1:0]       mem_rdata
);

    localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [LIW-1:0]        r_lane;
    logic [AW-1:0]         r_base;
    logic [LANES*LW-1:0]   r_wdata;
    logic [LANES*LW-1:0]   r_gather;
    logic [LANES*LW-1:0]   r_rdata;
    logic                  r_rdvalid;

    logic                  w_active;
    logic                  w_last;
    logic [AW-1:0]         w_base_in;
    logic [LANES*LW-1:0]   w_gather_next;

    assign w_active  = (r_state == S_WRITE) || (r_state == S_READ);
    assign w_last    = (r_lane == LIW'(LANES - 1));
    // Beats are word-sized, so the base is forced to word alignment.
    assign w_base_in = {ALUResultM[AW-1:2], 2'b00};

    // Gather buffer with the current beat merged in; the final beat's data
    // is only on mem_rdata, so ReadDataM is loaded from this merged view.
    always_comb begin
        w_gather_next = r_gather;
        w_gather_next[r_lane*LW +: LW] = mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        StallM       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                StallM = MemWriteM || MemtoRegM;
                if (MemWriteM) begin
                    w_state_next = S_WRITE;
                end else if (MemtoRegM) begin
                    w_state_next = S_READ;
                end
            end
            S_WRITE, S_READ: begin
                StallM   = 1'b1;
                mem_req  = 1'b1;
                mem_we   = (r_state == S_WRITE);
                // Address arithmetic wraps modulo 2^AW on purpose.
                mem_addr = r_base + (AW'(r_lane) << 2);
                if (r_state == S_WRITE) begin
                    mem_wdata = r_wdata[r_lane*LW +: LW];
                end
                if (mem_ack && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane    <= '0;
            r_base    <= '0;
            r_wdata   <= '0;
            r_gather  <= '0;
            r_rdata   <= '0;
            r_rdvalid <= 1'b0;
        end else begin
            r_rdvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (MemWriteM) begin
                        r_base  <= w_base_in;
                        r_wdata <= WriteDataM;
                        r_lane  <= '0;
                    end else if (MemtoRegM) begin
                        r_base  <= w_base_in;
                        r_lane  <= '0;
                    end
                end
                S_WRITE, S_READ: begin
                    if (mem_ack) begin
                        if (r_state == S_READ) begin
                            r_gather <= w_gather_next;
                        end
                        if (w_last) begin
                            r_lane <= '0;
                            // ReadDataM is fresh during DONE, aligned with RDValidM.
                            if (r_state == S_READ) begin
                                r_rdata   <= w_gather_next;
                                r_rdvalid <= 1'b1;
                            end
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ReadDataM = r_rdata;
    assign RDValidM  = r_rdvalid;

endmodule

// File: tb/tb_vec_mem_port.sv
module tb_vec_mem_port;

    logic         clk = 1'b0;
    logic         reset;
    logic         MemWriteM;
    logic         MemtoRegM;
    logic [255:0] ALUResultM;
    logic [255:0] WriteDataM;
    logic         StallM;
    logic [255:0] ReadDataM;
    logic         RDValidM;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    int           n_total = 0;
    int           n_pass  = 0;
    logic [255:0] exp_rdata;

    vec_mem_port dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .RDValidM   (RDValidM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Runs one request from the IDLE cycle through DONE. Expected beats are
    // derived directly from the transfer rules: word-aligned base plus 4 per
    // beat, store data lane by lane, load data placed in its beat's lane.
    // ack_mode: 0 = tied high, 1 = every third cycle, 2 = random.
    // pat: load data is 0xA0+beat instead of random.
    task automatic run_op(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [255:0] wdata, input int ack_mode, input bit pat);
        logic [31:0]  base;
        logic [255:0] gath;
        logic [31:0]  exp_wd;
        logic         ack;
        logic         is_wr;
        int           beat;
        int           cyc;
        is_wr = wr;
        base  = {addr[31:2], 2'b00};
        gath  = '0;

        ALUResultM = rand256();
        ALUResultM[31:0] = addr;
        WriteDataM = wdata;
        MemWriteM  = wr;
        MemtoRegM  = rd;
        mem_ack    = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        #1;
        n_total++; if (StallM !== 1'b1) $display("FAIL idle_stall: got %b want 1", StallM); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", mem_req); else n_pass++;
        n_total++; if (RDValidM !== 1'b0) $display("FAIL idle_rdvalid: got %b want 0", RDValidM); else n_pass++;
        @(posedge clk); #1;
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        WriteDataM = rand256();
        ALUResultM = rand256();

        beat = 0;
        cyc  = 1;
        while (beat < 8 && cyc < 200) begin
            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 3 == 0);
                default: ack = 1'($urandom_range(0, 1));
            endcase
            mem_ack   = ack;
            mem_rdata = pat ? (32'hA0 + 32'(beat)) : $urandom;
            exp_wd    = is_wr ? wdata[beat*32 +: 32] : 32'h0;
            #1;
            n_total++; if (mem_req !== 1'b1) $display("FAIL beat_req: beat %0d got %b want 1", beat, mem_req); else n_pass++;
            n_total++; if (mem_we !== is_wr) $display("FAIL beat_we: beat %0d got %b want %b", beat, mem_we, is_wr); else n_pass++;
            n_total++; if (mem_addr !== base + 32'(4 * beat)) $display("FAIL beat_addr: beat %0d got %h want %h", beat, mem_addr, base + 32'(4 * beat)); else n_pass++;
            n_total++; if (mem_wdata !== exp_wd) $display("FAIL beat_wdata: beat %0d got %h want %h", beat, mem_wdata, exp_wd); else n_pass++;
            n_total++; if (StallM !== 1'b1) $display("FAIL beat_stall: beat %0d got %b want 1", beat, StallM); else n_pass++;
            n_total++; if (RDValidM !== 1'b0) $display("FAIL beat_rdvalid: beat %0d got %b want 0", beat, RDValidM); else n_pass++;
            if (ack) begin
                if (!is_wr) gath[beat*32 +: 32] = mem_rdata;
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_total++; if (beat != 8) $display("FAIL beat_timeout: got %0d beats want 8", beat); else n_pass++;

        // DONE cycle: requests and stray acks must be ignored.
        if (!is_wr) exp_rdata = gath;
        mem_ack   = 1'($urandom_range(0, 1));
        MemWriteM = 1'($urandom_range(0, 1));
        MemtoRegM = 1'($urandom_range(0, 1));
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL done_req: got %b want 0", mem_req); else n_pass++;
        n_total++; if (StallM !== 1'b0) $display("FAIL done_stall: got %b want 0", StallM); else n_pass++;
        n_total++; if (RDValidM !== !is_wr) $display("FAIL done_rdvalid: got %b want %b", RDValidM, !is_wr); else n_pass++;
        n_total++; if (ReadDataM !== exp_rdata) $display("FAIL done_rdata: got %h want %h", ReadDataM, exp_rdata); else n_pass++;
        if (ack_mode == 0) begin
            n_total++; if (cyc != 9) $display("FAIL done_latency: got cycle %0d want 9", cyc); else n_pass++;
        end
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
        mem_ack   = 1'b0;
        @(posedge clk); #1;
        n_total++; if (RDValidM !== 1'b0) $display("FAIL post_rdvalid: got %b want 0", RDValidM); else n_pass++;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        exp_rdata  = '0;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", mem_addr); else n_pass++;
        n_total++; if (ReadDataM !== 256'h0) $display("FAIL rst_rdata: got %h want 0", ReadDataM); else n_pass++;
        n_total++; if (StallM !== 1'b0) $display("FAIL rst_stall_idle: got %b want 0", StallM); else n_pass++;
        MemWriteM = 1'b1;
        #1;
        n_total++; if (StallM !== 1'b1) $display("FAIL rst_stall_req: got %b want 1", StallM); else n_pass++;
        MemWriteM = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_release_req: got %b want 0", mem_req); else n_pass++;
    endtask

    task automatic test_store_tied();
        logic [255:0] wd;
        for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'h11111111 * 32'(i + 1);
        run_op(1'b1, 1'b0, 32'h100, wd, 0, 1'b0);
    endtask

    task automatic test_load_waits();
        run_op(1'b0, 1'b1, 32'h400, '0, 1, 1'b1);
        n_total++;
        if (ReadDataM !== 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0)
            $display("FAIL load_pattern: got %h", ReadDataM);
        else n_pass++;
    endtask

    task automatic test_wrap();
        run_op(1'b1, 1'b0, 32'hFFFFFFF6, rand256(), 0, 1'b0);
        run_op(1'b0, 1'b1, 32'hFFFFFFF6, '0, 2, 1'b0);
    endtask

    task automatic test_both_requests();
        run_op(1'b1, 1'b1, 32'h2000, rand256(), 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b0, 32'h300, rand256(), 0, 1'b0);
        run_op(1'b0, 1'b1, 32'h300, '0, 0, 1'b0);
        run_op(1'b0, 1'b1, 32'h340, '0, 2, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        MemtoRegM  = 1'b1;
        ALUResultM = 256'h200;
        @(posedge clk); #1;
        MemtoRegM = 1'b0;
        repeat (3) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        #1;
        n_total++; if (mem_addr !== 32'h20C) $display("FAIL mid_addr: got %h want 20c", mem_addr); else n_pass++;
        n_total++; if (ReadDataM !== exp_rdata) $display("FAIL mid_rdata_hold: got %h want %h", ReadDataM, exp_rdata); else n_pass++;
        reset = 1'b0;
        #1;
        exp_rdata = '0;
        n_total++; if (mem_req !== 1'b0) $display("FAIL arst_req: got %b want 0", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL arst_addr: got %h want 0", mem_addr); else n_pass++;
        n_total++; if (ReadDataM !== 256'h0) $display("FAIL arst_rdata: got %h want 0", ReadDataM); else n_pass++;
        n_total++; if (StallM !== 1'b0) $display("FAIL arst_stall: got %b want 0", StallM); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL arst_no_resume: got %b want 0", mem_req); else n_pass++;
        run_op(1'b1, 1'b0, 32'h500, rand256(), 2, 1'b0);
        run_op(1'b0, 1'b1, 32'h500, '0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic wr;
        logic rd;
        for (int n = 0; n < 12; n++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            run_op(wr, rd, $urandom, rand256(), $urandom_range(0, 2), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_store_tied();
        test_load_waits();
        test_wrap();
        test_both_requests();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vec_mem_port.md
Name: vec_mem_port

Overview:
- Memory-stage port for the 8-lane, 256-bit vector pipeline. It accepts a vector store (ALUResultM address, WriteDataM data, MemWriteM) or a vector load (MemtoRegM) from the EM pipeline register.
- A store is serialized into 8 sequential 32-bit beats on a narrow req/ack data-memory bus.
- A load gathers 8 beats from the same bus into a 256-bit ReadDataM for writeback.
- StallM freezes upstream stages until the transfer completes.

Parameters:
- LANES, 8, number of vector lanes (beats per transfer)
- LW, 32, lane and memory data width in bits
- AW, 32, memory address width in bits

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- MemWriteM  in  1  vector store request
- MemtoRegM  in  1  vector load request
- ALUResultM  in  LANES*LW  lane 0 ([AW-1:0]) is the base byte address; other lanes are ignored
- WriteDataM  in  LANES*LW  store data; lane i is [i*LW+LW-1 : i*LW]
- StallM  out  1  hold upstream pipeline registers
- ReadDataM  out  LANES*LW  gathered load data
- RDValidM  out  1  one-cycle pulse when ReadDataM has just been updated
- mem_req  out  1  memory beat request
- mem_we  out  1  beat is a write
- mem_addr  out  AW  beat byte address
- mem_wdata  out  LW  beat write data
- mem_ack  in  1  beat accepted (write) or data valid (read)
- mem_rdata  in  LW  read data, valid when mem_ack=1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset=0), including mid-transfer:
  - state=IDLE; lane counter=0; base and data registers=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, RDValidM=0.
  - StallM follows its combinational rule in IDLE.
  - An aborted transfer is dropped and is never resumed.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - If MemWriteM=1: capture the base address (ALUResultM[AW-1:0] with bits [1:0] forced to 0) and all of WriteDataM, set lane=0, go to WRITE.
  - Else if MemtoRegM=1: capture the base address the same way, set lane=0, go to READ.
  - If both requests are high, the store wins and the load is ignored (illegal encoding).
- WRITE / READ:
  - mem_req=1; mem_we=1 in WRITE, 0 in READ.
  - mem_addr = base + 4*lane, modulo 2^AW (the address wraps silently).
  - In WRITE, mem_wdata = captured lane[lane]; in READ, mem_wdata=0.
  - mem_req stays high until the beat is acknowledged.
  - On mem_ack=1: in READ, mem_rdata is written into the lane[lane] slot of the gather buffer.
  - If lane==LANES-1, go to DONE; otherwise increment lane. The next beat's address and data are presented in the following cycle, with mem_req still high, so there is no idle cycle between beats.
  - With mem_ack=0, all outputs hold stable.
- DONE (exactly one cycle):
  - mem_req=0.
  - For a read, ReadDataM is loaded from the gather buffer and RDValidM=1 that cycle.
  - Request inputs are ignored. Return to IDLE.
- ReadDataM holds its value until the next completed load; it is unchanged by stores.
- StallM (combinational): 1 when (IDLE and (MemWriteM or MemtoRegM)), or in WRITE, or in READ; 0 in DONE and in idle-with-no-request. The instruction retires on the DONE edge.
- mem_ack while mem_req=0 is ignored.
- Latency with mem_ack tied high: request seen in IDLE at cycle 0; beats in cycles 1–8; DONE in cycle 9; StallM high for cycles 0–8.

Test Plan:
- Store, ack tied high: base 0x100, WriteDataM lanes = 0x11111111..0x88888888 -> 8 write beats at 0x100..0x11C in 8 consecutive cycles with the matching data; StallM high 9 cycles; DONE in cycle 9; ReadDataM unchanged.
- Load with wait states: mem_ack asserted every third cycle, mem_rdata = 0xA0+beat -> ReadDataM = {0xA7,…,0xA0} (lane 0 = 0xA0); RDValidM single pulse; mem_addr stable during waits.
- Wrap and alignment: base 0xFFFFFFF6 -> addresses 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC, 0x0, …, 0x10.
- Simultaneous requests: MemWriteM=MemtoRegM=1 -> only the write sequence runs (mem_we=1 on all beats); no RDValidM pulse.
- Reset mid-op: assert reset after beat 3 of a load -> mem_req and ReadDataM go to 0 immediately (asynchronously); after release, state is IDLE and a new store completes correctly.
- Back-to-back: a load immediately follows a store -> the new request is accepted in the IDLE cycle after DONE; StallM is low for exactly the DONE cycle between the two transfers.
